btn_lane_conditioner: RTL

Parametrised input conditioner for the piano-tile lane switches. It synchronises and debounces N_CH raw switch inputs and drives the debounced levels straight to the lane LEDs. It generates one-cycle press and release pulses, and queues presses as lane-index events through a valid/ready handshake for the game logic. It sits between the board pins and the tile-scoring FSM.

---
 rtl/btn_pkg.sv | 19 +
 rtl/btn_debounce.sv | 99 +++++++++
 rtl/btn_lane_conditioner.sv | 98 +++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared constants, lane-index helpers and types for the lane-switch conditioner.
// Defaults target a 100 MHz core clock.
package btn_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int REPEAT_DELAY_DEF    = 50000000;
    localparam int REPEAT_PERIOD_DEF   = 20000000;
    localparam int MAX_LANES           = 32;

    // Width of a lane index; a single lane still gets a 1-bit index.
    function automatic int lane_w(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    localparam int LANE_W_MAX = lane_w(MAX_LANES);

    typedef logic [LANE_W_MAX-1:0] lane_idx_t;

endpackage

// File: rtl/btn_debounce.sv
// One lane: synchroniser, debouncer, press/release pulses, hold auto-repeat under BTN_REPEAT_EN.
// Latency: level/press update SYNC_STAGES+DEBOUNCE_CYCLES edges after the pin settles.
// Backpressure: none; pulses are one cycle wide and are never held.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
`ifdef BTN_REPEAT_EN
    ,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_in,
    output logic level,
    output logic press,
    output logic release_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   stable_q, stable_d;
    logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
    logic                   press_q, press_d;
    logic                   rel_q, rel_d;
    logic                   sync_s, differ, toggle;
    logic                   rep_fire;

`ifdef BTN_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = $clog2(RPT_MAX + 1);

    logic [RW-1:0] rep_cnt_q, rep_cnt_d, rep_inc, rep_target;
    logic          rep_armed_q, rep_armed_d;

    // rep_armed_q selects the period once the initial hold delay has elapsed.
    always_comb begin
        rep_inc     = rep_cnt_q + 1'b1;
        rep_target  = rep_armed_q ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY);
        rep_fire    = stable_q && !toggle && (rep_inc == rep_target);
        rep_cnt_d   = '0;
        rep_armed_d = 1'b0;
        if (stable_q && !toggle) begin
            rep_cnt_d   = rep_fire ? '0 : rep_inc;
            rep_armed_d = rep_armed_q | rep_fire;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_armed_q <= rep_armed_d;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], sw_in};
        sync_s   = sync_q[SYNC_STAGES-1];
        differ   = sync_s ^ stable_q;
        cnt_inc  = cnt_q + 1'b1;
        // Accept the new level on the sample that would complete the run.
        toggle   = differ && (cnt_inc == CW'(DEBOUNCE_CYCLES));
        stable_d = stable_q ^ toggle;
        cnt_d    = (differ && !toggle) ? cnt_inc : '0;
        press_d  = (toggle && !stable_q) || rep_fire;
        rel_d    = toggle && stable_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
            rel_q    <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
            rel_q    <= rel_d;
        end
    end

    assign level         = stable_q;
    assign press         = press_q;
    assign release_pulse = rel_q;

endmodule

// File: rtl/btn_lane_conditioner.sv
// N_CH-lane switch conditioner: debounced LEDs, edge pulses and a pending-mask press-event queue (BTN_REPEAT_EN adds hold repeat).
// Latency: ev_valid rises one cycle after press; an accepted lane clears at the accepting edge.
// Backpressure: ev_ready low keeps presses pending; a press on a still-pending lane sets sticky ovf.
module btn_lane_conditioner
    import btn_pkg::*;
#(
    parameter int N_CH            = 6,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
`ifdef BTN_REPEAT_EN
    ,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
`endif
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_CH-1:0]           sw_in,
    output logic [N_CH-1:0]           led_out,
    output logic [N_CH-1:0]           press,
    output logic [N_CH-1:0]           release_pulse,
    output logic                      ev_valid,
    output logic [lane_w(N_CH)-1:0]   ev_lane,
    input  logic                      ev_ready,
    output logic                      ovf,
    input  logic                      ovf_clr
);

    localparam int LW = lane_w(N_CH);

    logic [N_CH-1:0] pending_q, pending_d;
    logic [N_CH-1:0] clr_mask;
    logic [LW-1:0]   sel;
    logic            accept;
    logic            ovf_hit;
    logic            ovf_q, ovf_d;

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
`ifdef BTN_REPEAT_EN
        btn_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_deb (
            .clk           (clk),
            .rst_n         (rst_n),
            .sw_in         (sw_in[i]),
            .level         (led_out[i]),
            .press         (press[i]),
            .release_pulse (release_pulse[i])
        );
`else
        btn_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clk           (clk),
            .rst_n         (rst_n),
            .sw_in         (sw_in[i]),
            .level         (led_out[i]),
            .press         (press[i]),
            .release_pulse (release_pulse[i])
        );
`endif
    end

    always_comb begin
        // Scan downward so the lowest pending lane wins.
        sel = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel = LW'(i);
            end
        end
        ev_valid  = |pending_q;
        ev_lane   = sel;
        accept    = ev_valid && ev_ready;
        clr_mask  = accept ? (N_CH'(1) << sel) : '0;
        // A press landing on the lane being drained re-arms it without overflow.
        pending_d = (pending_q & ~clr_mask) | press;
        ovf_hit   = |(press & pending_q & ~clr_mask);
        ovf_d     = ovf_hit || (ovf_q && !ovf_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    assign ovf = ovf_q;

endmodule
